// File: rtl/mem_bus_pkg.sv
// Shared definitions for the peripheral bus sequencer: decoder selector codes,
// memory map constants, FSM/owner encodings and the wait-counter width helper.
package mem_bus_pkg;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_ROM  = 3'b001;
  localparam logic [2:0] SEL_GPIO = 3'b010;
  localparam logic [2:0] SEL_RAM  = 3'b100;

  localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE  = 32'h1001_0000;
  localparam logic [15:0] GPIO_OFS_A = 16'h0024;
  localparam logic [15:0] GPIO_OFS_B = 16'h0028;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Wait counter must hold the largest region wait; never narrower than one bit.
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between the IF port (req[0]) and the D port (req[1]).
// On a tie the port that did not own the bus last wins.
module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output logic       grant_valid,
  output owner_e     grant_owner
);

  always_comb begin
    grant_valid = |req;
    grant_owner = OWN_IF;
    if (req[1] && (!req[0] || last_owner == OWN_IF)) grant_owner = OWN_D;
  end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Shares one peripheral bus between the instruction-fetch and load/store ports,
// one transaction at a time, with per-region wait states and pre-strobe error checks.
//
// state     | meaning
// ST_IDLE   | bus free; arbitrate, ack the winner, drive its address
// ST_ADDR   | address on bus; classify decoder selector, flag errors
// ST_ACCESS | strobe phase, 1+WAIT cycles (strobes appear one cycle later)
// ST_RESP   | capture read data, pulse owner's rvalid, release bus
module mem_bus_sequencer
  import mem_bus_pkg::*;
#(
  parameter int unsigned ROM_WAIT  = 0,
  parameter int unsigned RAM_WAIT  = 1,
  parameter int unsigned GPIO_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] bus_adr,
  output logic        bus_memwrite,
  output logic        bus_memread,
  output logic [31:0] bus_wdata,
  input  logic [2:0]  bus_selector,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned MAX_RW   = (ROM_WAIT > RAM_WAIT) ? ROM_WAIT : RAM_WAIT;
  localparam int unsigned MAX_WAIT = (MAX_RW > GPIO_WAIT) ? MAX_RW : GPIO_WAIT;
  localparam int          WCW      = cnt_width(int'(MAX_WAIT));

  state_e           state;
  owner_e           owner;
  owner_e           last_owner;
  logic             lat_we;
  logic [31:0]      lat_wdata;
  logic             lat_err;
  logic             first_beat;
  logic [WCW-1:0]   wait_cnt;
  logic             grant_valid;
  owner_e           grant_owner;
  logic             access_err;
  logic [WCW-1:0]   region_wait;
  logic [31:0]      resp_data;

  rr_arbiter2 u_arb (
    .req         ({d_req, if_req}),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // bus_adr holds the latched address from grant until release, so its low bits
  // double as the alignment check source.
  always_comb begin
    access_err  = 1'b1;
    region_wait = '0;
    case (bus_selector)
      SEL_ROM: begin
        access_err  = lat_we || (bus_adr[1:0] != 2'b00);
        region_wait = WCW'(ROM_WAIT);
      end
      SEL_RAM: begin
        access_err  = (bus_adr[1:0] != 2'b00);
        region_wait = WCW'(RAM_WAIT);
      end
      SEL_GPIO: begin
        access_err  = 1'b0;
        region_wait = WCW'(GPIO_WAIT);
      end
      default: ;
    endcase
  end

  assign resp_data = (lat_err || lat_we) ? 32'h0 : bus_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      owner        <= OWN_IF;
      last_owner   <= OWN_D;
      lat_we       <= 1'b0;
      lat_wdata    <= '0;
      lat_err      <= 1'b0;
      first_beat   <= 1'b0;
      wait_cnt     <= '0;
      if_ack       <= 1'b0;
      if_rvalid    <= 1'b0;
      if_rdata     <= '0;
      if_err       <= 1'b0;
      d_ack        <= 1'b0;
      d_rvalid     <= 1'b0;
      d_rdata      <= '0;
      d_err        <= 1'b0;
      bus_adr      <= '0;
      bus_memwrite <= 1'b0;
      bus_memread  <= 1'b0;
      bus_wdata    <= '0;
    end else begin
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_err    <= 1'b0;
      d_err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner      <= grant_owner;
            last_owner <= grant_owner;
            state      <= ST_ADDR;
            if (grant_owner == OWN_D) begin
              d_ack     <= 1'b1;
              lat_we    <= d_we;
              lat_wdata <= d_wdata;
              bus_adr   <= d_addr;
            end else begin
              if_ack    <= 1'b1;
              lat_we    <= 1'b0;
              lat_wdata <= '0;
              bus_adr   <= if_addr;
            end
          end
        end
        ST_ADDR: begin
          lat_err <= access_err;
          if (access_err) begin
            bus_adr <= '0;
            state   <= ST_RESP;
          end else begin
            wait_cnt   <= region_wait;
            first_beat <= 1'b1;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          bus_memread  <= !lat_we;
          bus_memwrite <= lat_we && first_beat;
          bus_wdata    <= lat_we ? lat_wdata : 32'h0;
          first_beat   <= 1'b0;
          if (wait_cnt == '0) state <= ST_RESP;
          else wait_cnt <= wait_cnt - WCW'(1);
        end
        ST_RESP: begin
          // Last strobe cycle is visible now, so read data is sampled here.
          bus_memread  <= 1'b0;
          bus_memwrite <= 1'b0;
          bus_wdata    <= '0;
          bus_adr      <= '0;
          state        <= ST_IDLE;
          if (owner == OWN_D) begin
            d_rvalid <= 1'b1;
            d_rdata  <= resp_data;
            d_err    <= lat_err;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= resp_data;
            if_err    <= lat_err;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
